mc_ctrl: RTL

Multicycle control unit for the 8-bit processor. It owns the program counter, fetches 16-bit instructions over a request/acknowledge port, and sequences the 8x8 register file, the ALU and data memory through FETCH/DECODE/EXEC/MEM/WB. It drives register read and write addresses, the write strobe, and the memory-to-register select. It replaces ad-hoc per-cycle strobing of the register file.

---
 rtl/mc_pkg.sv | 50 +++++
 rtl/mc_decode.sv | 43 ++++
 rtl/mc_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, FSM states,
// ALU operation encodings, decoded control bundle and the imm6 sign extender.
package mc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } aluop_t;

  // Per-opcode control class produced by mc_decode.
  typedef struct packed {
    aluop_t aluop;
    logic   alusrc;
    logic   rtype;
    logic   mem;
    logic   mem_we;
    logic   memtoreg;
    logic   branch;
    logic   jump;
    logic   halt;
    logic   illegal;
  } ctrl_t;

  function automatic logic [15:0] sext_imm6(input logic [5:0] imm);
    return {{10{imm[5]}}, imm};
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode-to-control decoder for the multicycle control unit.
module mc_decode
  import mc_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        // R-type ops map their low opcode bits straight onto the ALU encoding.
        ctrl.aluop = aluop_t'(opcode[1:0]);
        ctrl.rtype = 1'b1;
      end
      OP_ADDI: begin
        ctrl.aluop  = ALU_ADD;
        ctrl.alusrc = 1'b1;
      end
      OP_LW: begin
        ctrl.aluop    = ALU_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.mem      = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      OP_SW: begin
        ctrl.aluop  = ALU_ADD;
        ctrl.alusrc = 1'b1;
        ctrl.mem    = 1'b1;
        ctrl.mem_we = 1'b1;
      end
      OP_BEQ: begin
        ctrl.aluop  = ALU_SUB;
        ctrl.branch = 1'b1;
      end
      OP_J:    ctrl.jump = 1'b1;
      OP_HALT: ctrl.halt = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control unit: PC, IR and the FETCH/DECODE/EXEC/MEM/WB sequencer
// driving the register file, ALU and data memory.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  // Fetch port: imem_req stays high until imem_ack is sampled; acks seen
  // while not requesting are ignored. The data port follows the same rule.
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [2:0]      ra1,
  output logic [2:0]      ra2,
  output logic [2:0]      wa,
  output logic            regwrite,
  output logic            memtoreg,
  output logic            alusrc,
  output logic [1:0]      aluop,
  input  logic            alu_zero,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            halted,
  output logic            illegal,
  output logic [2:0]      fsm_state
);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  aluop_t          aluop_q;
  logic            alusrc_q;
  logic            memtoreg_q;
  ctrl_t           ctrl;

  mc_decode u_decode (
    .opcode (ir[15:12]),
    .ctrl   (ctrl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      aluop_q    <= ALU_ADD;
      alusrc_q   <= 1'b0;
      memtoreg_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            pc    <= pc + PC_W'(1);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (ctrl.illegal) begin
            state <= S_FETCH;
          end else if (ctrl.halt) begin
            state <= S_HALT;
          end else if (ctrl.jump) begin
            pc    <= PC_W'(ir[7:0]);
            state <= S_FETCH;
          end else begin
            // ALU controls are loaded here so they are valid throughout EXEC
            // and stay stable until the write-back completes.
            aluop_q  <= ctrl.aluop;
            alusrc_q <= ctrl.alusrc;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (ctrl.branch) begin
            // PC already points past the branch, so the offset is added to PC+1.
            if (alu_zero) pc <= pc + PC_W'(sext_imm6(ir[5:0]));
            state <= S_FETCH;
          end else if (ctrl.mem) begin
            state <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (ctrl.mem_we) begin
              state <= S_FETCH;
            end else begin
              memtoreg_q <= ctrl.memtoreg;
              state      <= S_WB;
            end
          end
        end
        S_WB: begin
          memtoreg_q <= 1'b0;
          state      <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Reset parks the FSM in FETCH; masking with rst keeps the request low
  // until reset is released.
  assign imem_req  = (state == S_FETCH) && !rst;
  assign imem_addr = pc;

  assign ra1 = ir[8:6];
  assign ra2 = ctrl.rtype ? ir[5:3] : ir[11:9];
  assign wa  = ir[11:9];

  assign regwrite  = (state == S_WB);
  assign memtoreg  = memtoreg_q;
  assign alusrc    = alusrc_q;
  assign aluop     = aluop_q;
  assign dmem_req  = (state == S_MEM);
  assign dmem_we   = (state == S_MEM) && ctrl.mem_we;
  assign halted    = (state == S_HALT);
  assign illegal   = (state == S_DECODE) && ctrl.illegal;
  assign fsm_state = state;

endmodule
